// File: rtl/afpm_pkg.sv
// Shared constants and FSM encodings for the AFPM result transmit path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Optional macro AFPM_TX_CHECKSUM_EN adds the checksum-byte state encoding.
package afpm_pkg;

  localparam int AFPM_BYTE_W = 8;
  localparam int AFPM_FP16_W = 16;

  // Number of lane-sized bytes in one result word.
  function automatic int afpm_nbytes(input int data_w, input int byte_w);
    return data_w / byte_w;
  endfunction

  localparam int AFPM_NBYTES = afpm_nbytes(AFPM_FP16_W, AFPM_BYTE_W);

  // Transmit FSM encodings.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
`ifdef AFPM_TX_CHECKSUM_EN
  localparam logic [1:0] ST_CSUM = 2'd2;
`endif

endpackage

// File: rtl/afpm_result_serializer_if.sv
// Bundle for the serializer: result handshake in, framed byte stream out.
// Latency: n/a (wiring only).
// Backpressure: res_ready qualifies res_valid; the byte stream has no backpressure.
// master: result producer / byte consumer side.  slave: the serializer.
interface afpm_result_serializer_if #(
  parameter int DATA_W = 16,
  parameter int BYTE_W = 8
);
  logic [DATA_W-1:0] res_data;
  logic              res_valid;
  logic              res_ready;
  logic [BYTE_W-1:0] tx_byte;
  logic              tx_valid;
  logic              tx_first;
  logic              tx_last;
  logic              busy;

  modport master (
    output res_data, res_valid,
    input  res_ready, tx_byte, tx_valid, tx_first, tx_last, busy
  );

  modport slave (
    input  res_data, res_valid,
    output res_ready, tx_byte, tx_valid, tx_first, tx_last, busy
  );
endinterface

// File: rtl/afpm_sync_fifo.sv
// Small synchronous FIFO with occupancy count and same-cycle push/pop.
// Latency: a pushed word is visible at pop_dat the cycle after the push.
// Backpressure: none internally; caller must not push when full or pop when empty.
// Ports: clk, rst_n (async active-low), push/push_dat, pop/pop_dat, count.
module afpm_sync_fifo #(
  parameter  int W     = 16,
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [W-1:0]     push_dat,
  input  logic             pop,
  output logic [W-1:0]     pop_dat,
  output logic [CNT_W-1:0] count
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // DEPTH is a power of two, so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_dat;
  end

  assign pop_dat = mem_q[rd_ptr_q];
  assign count   = count_q;

endmodule

// File: rtl/afpm_result_serializer.sv
// Buffers 16-bit results and streams them LSB byte first with first/last strobes.
// Latency: 1 cycle from accept (idle, empty queue) to byte 0; frames run back-to-back.
// Backpressure: res_ready low when queue is full, ena is low or reset is asserted.
// Ports: clk, rst_n (async active-low), ena (freeze when low), bus (slave modport).
// Optional macro AFPM_TX_CHECKSUM_EN appends an XOR checksum byte to every frame.
module afpm_result_serializer
  import afpm_pkg::*;
#(
  parameter int          DATA_W     = AFPM_FP16_W,
  parameter int          BYTE_W     = AFPM_BYTE_W,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [7:0]  IDLE_BYTE  = 8'h00
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena,
  afpm_result_serializer_if.slave bus
);

  localparam int NB     = afpm_nbytes(DATA_W, BYTE_W);
  localparam int CNT_W  = $clog2(NB + 1);
  localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] NB_C = CNT_W'(NB);

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;     // bytes of the current word already emitted
  logic [BYTE_W-1:0] tx_byte_q, tx_byte_d;
  logic              tx_valid_q, tx_valid_d;
  logic              tx_first_q, tx_first_d;
  logic              tx_last_q, tx_last_d;
  logic              busy_q, busy_d;
`ifdef AFPM_TX_CHECKSUM_EN
  logic [BYTE_W-1:0] csum_q, csum_d;
`endif

  logic              fifo_push, fifo_pop, fifo_empty;
  logic [DATA_W-1:0] fifo_dat;
  logic [FCNT_W-1:0] fifo_cnt, fifo_cnt_nxt;
  logic              res_ready, accept, bypass;
  logic              next_frame, start;
  logic [DATA_W-1:0] start_word;

  afpm_sync_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (fifo_push),
    .push_dat (bus.res_data),
    .pop      (fifo_pop),
    .pop_dat  (fifo_dat),
    .count    (fifo_cnt)
  );

  assign res_ready  = ena & rst_n & (fifo_cnt < FCNT_W'(FIFO_DEPTH));
  assign accept     = bus.res_valid & res_ready;
  assign fifo_empty = (fifo_cnt == '0);
  // Only an idle serializer with nothing queued may load straight from the bus;
  // anything else keeps ordering by going through the FIFO.
  assign bypass     = accept & (state_q == ST_IDLE) & fifo_empty;

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    cnt_d        = cnt_q;
    tx_byte_d    = tx_byte_q;
    tx_valid_d   = tx_valid_q;
    tx_first_d   = tx_first_q;
    tx_last_d    = tx_last_q;
    busy_d       = busy_q;
    fifo_push    = 1'b0;
    fifo_pop     = 1'b0;
    next_frame   = 1'b0;
    start        = 1'b0;
    start_word   = fifo_dat;
    fifo_cnt_nxt = fifo_cnt;
`ifdef AFPM_TX_CHECKSUM_EN
    csum_d       = csum_q;
`endif
    if (ena) begin
      fifo_push = accept & ~bypass;
      case (state_q)
        ST_SEND: begin
          if (cnt_q != NB_C) begin
            tx_byte_d  = shreg_q[BYTE_W-1:0];
            shreg_d    = shreg_q >> BYTE_W;
            cnt_d      = cnt_q + CNT_W'(1);
            tx_valid_d = 1'b1;
            tx_first_d = 1'b0;
`ifdef AFPM_TX_CHECKSUM_EN
            tx_last_d  = 1'b0;
            csum_d     = csum_q ^ shreg_q[BYTE_W-1:0];
`else
            tx_last_d  = (cnt_q == NB_C - CNT_W'(1));
`endif
          end else begin
`ifdef AFPM_TX_CHECKSUM_EN
            tx_byte_d  = csum_q;
            tx_valid_d = 1'b1;
            tx_first_d = 1'b0;
            tx_last_d  = 1'b1;
            state_d    = ST_CSUM;
`else
            next_frame = 1'b1;
`endif
          end
        end
        default: next_frame = 1'b1;  // idle, or checksum byte just went out
      endcase

      if (next_frame) begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          start      = 1'b1;
          start_word = fifo_dat;
        end else if (bypass) begin
          start      = 1'b1;
          start_word = bus.res_data;
        end else begin
          state_d    = ST_IDLE;
          tx_byte_d  = IDLE_BYTE[BYTE_W-1:0];
          tx_valid_d = 1'b0;
          tx_first_d = 1'b0;
          tx_last_d  = 1'b0;
        end
      end

      // Byte 0 is emitted in the same cycle the word is loaded.
      if (start) begin
        state_d    = ST_SEND;
        tx_byte_d  = start_word[BYTE_W-1:0];
        shreg_d    = start_word >> BYTE_W;
        cnt_d      = CNT_W'(1);
        tx_valid_d = 1'b1;
        tx_first_d = 1'b1;
`ifdef AFPM_TX_CHECKSUM_EN
        tx_last_d  = 1'b0;
        csum_d     = start_word[BYTE_W-1:0];
`else
        tx_last_d  = (NB == 1);
`endif
      end

      fifo_cnt_nxt = fifo_cnt + FCNT_W'(fifo_push) - FCNT_W'(fifo_pop);
      busy_d       = (state_d != ST_IDLE) | (fifo_cnt_nxt != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      shreg_q    <= '0;
      cnt_q      <= '0;
      tx_byte_q  <= IDLE_BYTE[BYTE_W-1:0];
      tx_valid_q <= 1'b0;
      tx_first_q <= 1'b0;
      tx_last_q  <= 1'b0;
      busy_q     <= 1'b0;
`ifdef AFPM_TX_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      cnt_q      <= cnt_d;
      tx_byte_q  <= tx_byte_d;
      tx_valid_q <= tx_valid_d;
      tx_first_q <= tx_first_d;
      tx_last_q  <= tx_last_d;
      busy_q     <= busy_d;
`ifdef AFPM_TX_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign bus.res_ready = res_ready;
  assign bus.tx_byte   = tx_byte_q;
  assign bus.tx_valid  = tx_valid_q;
  assign bus.tx_first  = tx_first_q;
  assign bus.tx_last   = tx_last_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_afpm_result_serializer.sv
// Scoreboard bench for afpm_result_serializer: directed FP16 words in,
// expected {byte, first, last} queued on accept, monitor checks each byte out.
// Also checks reset values, latency, gap-free streaming, full queue, freeze and async reset.
module tb_afpm_result_serializer;

`ifdef AFPM_TX_CHECKSUM_EN
  localparam int  FL   = 3;
  localparam bit  CSUM = 1'b1;
`else
  localparam int  FL   = 2;
  localparam bit  CSUM = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic ena   = 1'b0;
  logic adv   = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  logic [9:0] exp_q[$];

  always #5 clk = ~clk;

  afpm_result_serializer_if #(.DATA_W(16), .BYTE_W(8)) bus ();

  afpm_result_serializer #(
    .DATA_W(16), .BYTE_W(8), .FIFO_DEPTH(2), .IDLE_BYTE(8'h00)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .bus   (bus)
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  // Expected frame for one word: low byte (first), high byte, optional XOR byte.
  function automatic void expect_word(input logic [15:0] w);
    exp_q.push_back({w[7:0], 1'b1, 1'b0});
    exp_q.push_back({w[15:8], 1'b0, !CSUM});
    if (CSUM) exp_q.push_back({w[7:0] ^ w[15:8], 1'b0, 1'b1});
  endfunction

  // Outputs only advance on an edge where ena was high.
  always @(posedge clk) adv <= ena;

  always @(negedge clk) begin
    if (bus.tx_valid && adv) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_byte: got %h first=%b last=%b, expected no byte",
                 bus.tx_byte, bus.tx_first, bus.tx_last);
      end else begin
        chk("stream_byte", {22'd0, bus.tx_byte, bus.tx_first, bus.tx_last},
            {22'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic push_word(input logic [15:0] w);
    bit ok;
    ok = 1'b0;
    bus.res_data  = w;
    bus.res_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.res_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("push_timeout", 32'd0, 32'd1);
    @(posedge clk);
    if (ok) expect_word(w);
    #1;
    bus.res_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    bus.res_valid = 1'b0;
    bus.res_data  = '0;
    rst_n = 1'b0;
    ena   = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset / idle state
    @(negedge clk);
    chk("rst_tx_valid", bus.tx_valid, 0);
    chk("rst_tx_byte", bus.tx_byte, 8'h00);
    chk("rst_first_last", {bus.tx_first, bus.tx_last}, 0);
    chk("rst_res_ready", bus.res_ready, 1);
    chk("rst_busy", bus.busy, 0);

    // Single frame 16'h4480: byte 0 one cycle after accept
    @(posedge clk); #1;
    push_word(16'h4480);
    @(negedge clk);
    chk("lat1_valid", bus.tx_valid, 1);
    chk("lat1_first", bus.tx_first, 1);
    chk("lat1_busy", bus.busy, 1);
    repeat (FL) @(negedge clk);
    chk("single_idle_valid", bus.tx_valid, 0);
    chk("single_idle_byte", bus.tx_byte, 8'h00);
    chk("single_idle_busy", bus.busy, 0);

    // Back-to-back: three words on consecutive cycles, no gap between frames
    @(posedge clk); #1;
    push_word(16'h3e00);
    push_word(16'h4200);
    push_word(16'h4480);
    for (int i = 0; i < 3*FL - 2; i++) begin
      @(negedge clk);
      chk("b2b_no_gap", bus.tx_valid, 1);
    end
    @(negedge clk);
    chk("b2b_end_idle", bus.tx_valid, 0);

    // Fill the queue: ready must drop with two words queued behind the active one
    @(posedge clk); #1;
    push_word(16'h3c00);
    push_word(16'h4000);
    push_word(16'h4200);
    push_word(16'h4400);
    @(negedge clk);
    chk("full_ready_low", bus.res_ready, 0);
    chk("full_busy", bus.busy, 1);
    repeat (4*FL + 2) @(negedge clk);
    chk("drain_valid", bus.tx_valid, 0);
    chk("drain_busy", bus.busy, 0);
    chk("drain_ready", bus.res_ready, 1);

    // Freeze after byte 00 of 16'h3e00 for three cycles
    @(posedge clk); #1;
    push_word(16'h3e00);
    ena = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("freeze_byte", {bus.tx_valid, bus.tx_first, bus.tx_byte}, {2'b11, 8'h00});
      chk("freeze_ready", bus.res_ready, 0);
    end
    ena = 1'b1;
    @(negedge clk);
    chk("resume_byte", {bus.tx_valid, bus.tx_byte, bus.tx_last}, {1'b1, 8'h3e, !CSUM});
    repeat (FL + 1) @(negedge clk);
    chk("resume_idle", bus.tx_valid, 0);

    // Async reset while sending 16'h4200 with 16'h4480 queued
    @(posedge clk); #1;
    push_word(16'h4200);
    push_word(16'h4480);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", bus.tx_valid, 0);
    chk("arst_byte", bus.tx_byte, 8'h00);
    chk("arst_flags", {bus.tx_first, bus.tx_last}, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_ready", bus.res_ready, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("post_rst_quiet", bus.tx_valid, 0);
    end
    chk("post_rst_ready", bus.res_ready, 1);
    chk("post_rst_busy", bus.busy, 0);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/afpm_result_serializer.md
Name: afpm_result_serializer

Overview:
Transmit end of the byte-serial link used by the tt_um_logarithmic_afpm top level. On the input side, operands arrive as two 8-bit lanes, low byte first, one byte per clock. This block takes finished 16-bit FP16 products from the multiplier core through a valid/ready handshake and buffers them. It then drives each product onto uo_out the same way: low byte first, one byte per clock, with framing strobes.

Parameters:
DATA_W, 16, result word width; must be an integer multiple of BYTE_W.
BYTE_W, 8, output lane width (uo_out width).
FIFO_DEPTH, 2, number of queued results held behind the active shift register (power of 2, >=2).
IDLE_BYTE, 8'h00, value driven on tx_byte when no frame is active.

Ports:
clk  input  1  system clock; the only clock in the block.
rst_n  input  1  asynchronous active-low reset.
ena  input  1  design-enable; low freezes all state.
res_data  input  DATA_W  result word from the multiplier core.
res_valid  input  1  res_data valid.
res_ready  output  1  block can accept a word this cycle.
tx_byte  output  BYTE_W  serialized byte, intended to feed uo_out.
tx_valid  output  1  tx_byte carries frame data.
tx_first  output  1  tx_byte is byte 0 (LSB) of a frame.
tx_last  output  1  tx_byte is the final (MSB) byte of a frame.
busy  output  1  frame active or FIFO non-empty.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: tx_byte=IDLE_BYTE; tx_valid=0, tx_first=0, tx_last=0; busy=0; FIFO empty; state=IDLE.
- res_ready is combinational: ena & rst_n & (fifo_count < FIFO_DEPTH).
- Handshake: a word is accepted at a rising edge where res_valid & res_ready. Upstream holds res_data stable while valid and not ready.
- NBYTES = DATA_W/BYTE_W. All outputs are registered.
- FSM states:
  - IDLE → SEND when a word is available. Bypass path: if the FIFO is empty and state is IDLE, an accepted word loads the shift register directly, and byte 0 appears in the following cycle (latency 1). Otherwise the head of the FIFO is popped into the shift register.
  - SEND: byte counter runs 0..NBYTES-1. Each cycle, tx_byte = shreg[BYTE_W-1:0], then shreg shifts right by BYTE_W. tx_first is set when count=0; tx_last is set when count=NBYTES-1.
  - On the last byte: if the FIFO is non-empty, pop and start the next frame with no gap cycle. Otherwise return to IDLE, where tx_byte=IDLE_BYTE and tx_valid=0.
- Push and pop in the same cycle: both happen; fifo_count is unchanged.
- Full: res_ready=0. Total capacity is FIFO_DEPTH queued words plus 1 in flight.
- ena=0: no shift, no push, no pop, outputs hold their values, res_ready=0. Resuming continues the same frame at the same byte index.
- Reset mid-frame: the frame is abandoned and the queue is flushed. Outputs return to reset values asynchronously.
- Pointers and counter wrap modulo their range. There are no partial frames except on reset.

Optional Feature:
Macro AFPM_TX_CHECKSUM_EN.
- Defined: after the last data byte of each frame, one extra byte is sent. It is the XOR of all NBYTES data bytes. tx_valid=1 and tx_last=1 on the checksum byte; tx_last is not asserted on the MSB data byte. The frame is NBYTES+1 cycles, and back-to-back frames still have no gap.
- Undefined: frames are exactly NBYTES bytes, and no checksum logic is synthesized.

Decomposition:
- Package afpm_pkg holds:
  - BYTE_W and FP16 width constants;
  - NBYTES function/localparam;
  - tx state enum (IDLE, SEND, plus CSUM under the macro).
- Sub-module afpm_sync_fifo: parameterized synchronous FIFO with count output, async active-low reset, and simultaneous push/pop.
- The serializer FSM, bypass path and output registers live in afpm_result_serializer.

Test Plan:
- Reset then idle: hold rst_n=0 for 2 cycles, then release → tx_valid=0, tx_byte=8'h00, res_ready=1, busy=0.
- Single frame: push 16'h4480 (1.5×3.0=4.5) when idle → next cycle tx_byte=8'h80 with first=1; following cycle tx_byte=8'h44 with last=1; then idle.
- Back-to-back with queue full: push 16'h3e00, 16'h4200 and 16'h4480 on consecutive cycles.
  - Expected bytes: 00,3e,00,42,80,44, with no gaps.
  - res_ready drops when the FIFO holds 2 words.
- Freeze: drop ena after byte 8'h00 of 16'h3e00 for 3 cycles → outputs hold. On resume, 8'h3e is sent with last=1.
- Async reset mid-frame: assert rst_n=0 between clock edges while sending 16'h4200 with one word queued → outputs reset immediately; no further bytes after release.
- With AFPM_TX_CHECKSUM_EN, push 16'h4480 → bytes 80, 44, c4. last=1 only on c4.
